exec_unit: RTL
==============

Name: exec_unit

Overview:
Parametrised successor to the register-file + source-mux + ULA datapath. It is a register bank with a hardwired-zero r0 and an ALU with an immediate/register B-source select. A command handshake and an FSM sequence each operation. It adds a multi-cycle shift-add multiply, a registered zero flag, a done pulse, and a debug read port for the LCD/HEX displays.

Parameters:
WIDTH, 8, datapath and register width in bits (min 4)
ADDR_W, 3, register address width; register count NREGS = 2**ADDR_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
cmd_valid  input  1  command present
cmd_ready  output  1  unit can accept a command
cmd_op  input  3  operation code (see Behaviour)
cmd_wa  input  ADDR_W  destination register
cmd_ra1  input  ADDR_W  source A register
cmd_ra2  input  ADDR_W  source B register
cmd_src_imm  input  1  1: B = cmd_imm; 0: B = reg[cmd_ra2]
cmd_imm  input  WIDTH  immediate operand
busy  output  1  command in flight
done  output  1  one-cycle pulse on completion
result  output  WIDTH  last completed result, registered
zero  output  1  result == 0, registered
dbg_ra  input  ADDR_W  debug read address
dbg_rd  output  WIDTH  combinational reg[dbg_ra]

Behaviour:
- Opcodes: 000 AND; 001 OR; 010 ADD; 011 XOR; 100 MUL (low WIDTH bits of A*B, unsigned); 101 PASSB; 110 SUB (A-B); 111 SLT (signed A<B gives 1, else 0).
- ADD, SUB and MUL wrap modulo 2**WIDTH. No carry or overflow outputs.
- r0 always reads 0 on every read port, including dbg_rd.
  - Writes to r0 are discarded.
  - result and zero still update on a write to r0.
- States: IDLE, EXEC, MUL.
- cmd_ready = (state == IDLE). busy = (state != IDLE).
- Accept occurs at the rising edge where cmd_valid && cmd_ready.
  - The accept edge captures op, wa, A and B into internal registers.
  - Operands are read at accept time.
- IDLE -> EXEC on accept of any op other than MUL. IDLE -> MUL on accept of MUL.
- EXEC: at the next edge:
  - write reg[wa];
  - update result and zero;
  - assert done for the following cycle;
  - return to IDLE.
  - Latency is 1 cycle from accept to writeback.
- MUL: shift-add, one multiplier bit per edge, iteration counter 0..WIDTH-1.
  - At the WIDTH-th edge after accept: write back, update result/zero, assert done, return to IDLE.
  - Latency is WIDTH cycles.
- Throughput: a new accept is possible at the edge after writeback. Minimum spacing is 2 cycles for single-cycle ops and WIDTH+1 cycles for MUL.
- cmd_valid while busy: ignored, not queued. The master must hold cmd_valid until it sees cmd_ready high.
- No read-after-write hazard: writeback completes before the next accept.
- dbg_rd reflects a write from the cycle after the writeback edge.
- done is high for exactly one cycle per command. It is never asserted without an accepted command.
- Reset (rst = 0, asynchronous, at any time including mid-MUL):
  - all registers and the result register go to 0; zero = 1;
  - state = IDLE; done = 0; busy = 0;
  - any in-flight command is aborted and produces no done and no writeback.
  - cmd_ready = 1 from the first edge after rst is released.
- Illegal opcodes: none exist; all 8 codes are defined.

Decomposition:
- Shared package exec_pkg: opcode localparams (OP_AND .. OP_SLT) and the FSM state encoding (S_IDLE, S_EXEC, S_MUL).
- Natural sub-module: regfile_3r1w (parametrised WIDTH/ADDR_W; two operand reads, one debug read, one write, r0 hardwired, async active-low reset).
- ALU combinational logic and the MUL sequencer stay in exec_unit.

Test Plan:
- Reset then idle → cmd_ready=1, busy=0, done=0, result=0x00, zero=1, dbg_rd=0 for all addresses.
- PASSB, src_imm=1, imm=0x2A, wa=1 → done exactly 1 cycle after accept; result=0x2A, zero=0; dbg_ra=1 gives 0x2A. Then r2 = 0x20 by the same method.
- r1=0xF0, r2=0x20: ADD to wa=3 → 0x10 (wrap). Then SUB r1-r1 to wa=4 → 0x00, zero=1.
- r1=0x0D, MUL with imm 0x0B to wa=5 → busy high 8 cycles, done at cycle 8, result=0x8F. A cmd_valid pulse during busy is not accepted and does not change r5.
- r1=0x80, SLT with imm 0x01 → 0x01. PASSB imm 0x55 to wa=0 → result=0x55 and dbg r0 still 0x00.
- MUL started, rst low at cycle 4 after accept → no done; all registers read 0; zero=1; accept possible one cycle after release.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared opcode and FSM state encodings for the exec_unit datapath.
package exec_pkg;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_XOR   = 3'b011;
    localparam logic [2:0] OP_MUL   = 3'b100;
    localparam logic [2:0] OP_PASSB = 3'b101;
    localparam logic [2:0] OP_SUB   = 3'b110;
    localparam logic [2:0] OP_SLT   = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;

endpackage

// File: rtl/regfile_3r1w.sv
// Register bank: two operand reads, one debug read, one write port.
// r0 is hardwired to zero on every read port and ignores writes.
module regfile_3r1w #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]  wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] dbg_ra,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    output logic [WIDTH-1:0]  dbg_rd
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1    = (ra1    == '0) ? '0 : regs[ra1];
    assign rd2    = (ra2    == '0) ? '0 : regs[ra2];
    assign dbg_rd = (dbg_ra == '0) ? '0 : regs[dbg_ra];

endmodule

// File: rtl/exec_unit.sv
// Register bank plus ALU sequenced by a command handshake; MUL runs as an
// iterative shift-add over WIDTH cycles, all other ops complete in one.
module exec_unit
    import exec_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_wa,
    input  logic [ADDR_W-1:0] cmd_ra1,
    input  logic [ADDR_W-1:0] cmd_ra2,
    input  logic              cmd_src_imm,
    input  logic [WIDTH-1:0]  cmd_imm,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    input  logic [ADDR_W-1:0] dbg_ra,
    output logic [WIDTH-1:0]  dbg_rd
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]        state;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] wa_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;
    logic [WIDTH-1:0]  alu_out;
    logic [WIDTH-1:0]  mul_next;
    logic [WIDTH-1:0]  wd;
    logic              mul_last;
    logic              we;

    regfile_3r1w #(
        .WIDTH (WIDTH),
        .ADDR_W(ADDR_W)
    ) u_regs (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .wa    (wa_q),
        .wd    (wd),
        .ra1   (cmd_ra1),
        .ra2   (cmd_ra2),
        .dbg_ra(dbg_ra),
        .rd1   (rd1),
        .rd2   (rd2),
        .dbg_rd(dbg_rd)
    );

    always_comb begin
        alu_out = '0;
        case (op_q)
            OP_AND:   alu_out = a_q & b_q;
            OP_OR:    alu_out = a_q | b_q;
            OP_ADD:   alu_out = a_q + b_q;
            OP_XOR:   alu_out = a_q ^ b_q;
            OP_PASSB: alu_out = b_q;
            OP_SUB:   alu_out = a_q - b_q;
            OP_SLT:   alu_out = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default:  alu_out = '0;
        endcase
    end

    // During MUL, a_q holds the left-shifted multiplicand and b_q the
    // right-shifted multiplier, so bit 0 of b_q selects each partial product.
    assign mul_next  = acc + (b_q[0] ? a_q : '0);
    assign mul_last  = (state == S_MUL) && (cnt == CNT_LAST);
    assign we        = (state == S_EXEC) || mul_last;
    assign wd        = (state == S_MUL) ? mul_next : alu_out;
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            op_q   <= '0;
            wa_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            zero   <= 1'b1;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        wa_q  <= cmd_wa;
                        a_q   <= rd1;
                        b_q   <= cmd_src_imm ? cmd_imm : rd2;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= (cmd_op == OP_MUL) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    result <= wd;
                    zero   <= (wd == '0);
                    done   <= 1'b1;
                    state  <= S_IDLE;
                end
                S_MUL: begin
                    acc <= mul_next;
                    a_q <= a_q << 1;
                    b_q <= b_q >> 1;
                    cnt <= cnt + 1'b1;
                    if (mul_last) begin
                        result <= wd;
                        zero   <= (wd == '0);
                        done   <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
